// File: rtl/dm_pkg.sv
// Shared types for the data-memory write buffer.
//   LINE_WORDS    : CPU words per memory line
//   line_addr_t,
//   word_t,
//   line_t,
//   mask_t        : default-width entry field types
//   drain_state_e : drain FSM states
//   word_onehot() : word-select to one-hot word enable
package dm_pkg;

    localparam int unsigned LINE_WORDS = 4;

    typedef logic [12:0]               line_addr_t;
    typedef logic [31:0]               word_t;
    typedef logic [LINE_WORDS*32-1:0]  line_t;
    typedef logic [LINE_WORDS-1:0]     mask_t;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} drain_state_e;

    function automatic mask_t word_onehot(input logic [1:0] sel);
        word_onehot = mask_t'(1) << sel;
    endfunction

endpackage

// File: rtl/dm_wb_fifo.sv
// Entry storage for the write buffer: circular FIFO of {line, line data, word mask}.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   push, merge               : write an entry; merge=1 folds it into the tail entry instead
//   push_line/sel/data        : line address, word slot and word data of the write
//   pop                       : retire the head entry
//   head_line/data/mask       : head entry contents
//   tail_line                 : line address of the most recently allocated entry
//   count                     : number of valid entries
//   ent_valid/line/mask       : per-slot view of all entries, for hazard checks
module dm_wb_fifo
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LA_W   = 13,
    parameter int unsigned WORD_W = 32,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1,
    localparam int unsigned LW    = LINE_WORDS * WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              merge,
    input  logic [LA_W-1:0]   push_line,
    input  logic [1:0]        push_sel,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [LA_W-1:0]   head_line,
    output logic [LW-1:0]     head_data,
    output mask_t             head_mask,
    output logic [LA_W-1:0]   tail_line,
    output logic [CW-1:0]     count,
    output logic [DEPTH-1:0]  ent_valid,
    output logic [LA_W-1:0]   ent_line [DEPTH],
    output mask_t             ent_mask [DEPTH]
);

    logic [LA_W-1:0] line_q [DEPTH];
    logic [LW-1:0]   data_q [DEPTH];
    mask_t           mask_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q, tail_idx, valid_off;
    logic [CW-1:0]   count_q;
    logic            alloc;

    assign alloc    = push && !merge;
    assign tail_idx = wr_ptr_q - PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (alloc) begin
                line_q[wr_ptr_q] <= push_line;
                data_q[wr_ptr_q] <= LW'(push_data) << (push_sel * WORD_W);
                mask_q[wr_ptr_q] <= word_onehot(push_sel);
            end
            if (merge) begin
                data_q[tail_idx][push_sel*WORD_W +: WORD_W] <= push_data;
                mask_q[tail_idx] <= mask_q[tail_idx] | word_onehot(push_sel);
            end
            wr_ptr_q <= wr_ptr_q + PW'(alloc);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            case ({alloc, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_line = line_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign head_mask = mask_q[rd_ptr_q];
    assign tail_line = line_q[tail_idx];
    assign count     = count_q;
    assign ent_line  = line_q;
    assign ent_mask  = mask_q;

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        ent_valid = '0;
        valid_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_off    = PW'(i) - rd_ptr_q;
            ent_valid[i] = {1'b0, valid_off} < count_q;
        end
    end

endmodule

// File: rtl/dm_write_buffer.sv
// Data-memory write buffer: queues CPU word writes and drains them as masked line writes.
// Optional feature macro: DM_WRITE_BUFFER_COALESCE_EN (merge writes to the tail entry's line).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   wr_valid/wr_ready              : CPU write handshake
//   wr_addr, wr_data               : word address ([1:0] word slot) and data
//   mem_wr_req/addr/data/mask      : registered line-write request to data memory
//   mem_wr_ack                     : memory accepted the current request
//   rd_addr, rd_hazard             : read-path probe; 1 while a write to that word is pending
//   empty                          : no entries queued and drain FSM idle
module dm_write_buffer
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned WORD_W = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [WORD_W-1:0]              wr_data,
    output logic                           mem_wr_req,
    output logic [ADDR_W-3:0]              mem_wr_addr,
    output logic [LINE_WORDS*WORD_W-1:0]   mem_wr_data,
    output logic [LINE_WORDS-1:0]          mem_wr_mask,
    input  logic                           mem_wr_ack,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic                           rd_hazard,
    output logic                           empty
);

    localparam int unsigned LA_W = ADDR_W - 2;
    localparam int unsigned LW   = LINE_WORDS * WORD_W;
    localparam int unsigned CW   = $clog2(DEPTH) + 1;

    logic [LA_W-1:0]  head_line, tail_line;
    logic [LW-1:0]    head_data;
    mask_t            head_mask;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] ent_valid;
    logic [LA_W-1:0]  ent_line [DEPTH];
    mask_t            ent_mask [DEPTH];
    logic             full, merge_ok, push, merge, pop;
    drain_state_e     state_q;

    assign full = (count == CW'(DEPTH));

`ifdef DM_WRITE_BUFFER_COALESCE_EN
    // Merging needs the tail to be distinct from the head: with a single entry the head is
    // either being loaded (IDLE), in flight (ISSUE) or waiting out GAP, none of which may
    // change under the drain FSM.
    assign merge_ok = (count >= CW'(2)) && (tail_line == wr_addr[ADDR_W-1:2]);
    assign wr_ready = !full || merge_ok;
`else
    logic unused_tail;
    assign unused_tail = ^tail_line;
    assign merge_ok    = 1'b0;
    assign wr_ready    = !full;
`endif

    assign push  = wr_valid && wr_ready;
    assign merge = push && merge_ok;
    assign pop   = (state_q == ISSUE) && mem_wr_ack;

    dm_wb_fifo #(
        .DEPTH  (DEPTH),
        .LA_W   (LA_W),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .merge     (merge),
        .push_line (wr_addr[ADDR_W-1:2]),
        .push_sel  (wr_addr[1:0]),
        .push_data (wr_data),
        .pop       (pop),
        .head_line (head_line),
        .head_data (head_data),
        .head_mask (head_mask),
        .tail_line (tail_line),
        .count     (count),
        .ent_valid (ent_valid),
        .ent_line  (ent_line),
        .ent_mask  (ent_mask)
    );

    // Drain FSM; request fields are captured on entry to ISSUE and held until the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_mask <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (count != '0) begin
                        mem_wr_addr <= head_line;
                        mem_wr_data <= head_data;
                        mem_wr_mask <= head_mask;
                        mem_wr_req  <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_wr_ack) begin
                        mem_wr_req <= 1'b0;
                        state_q    <= GAP;
                    end
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The in-flight head stays in the FIFO until its pop, so it is covered here too.
    always_comb begin
        rd_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_line[i] == rd_addr[ADDR_W-1:2]) &&
                ent_mask[i][rd_addr[1:0]]) begin
                rd_hazard = 1'b1;
            end
        end
    end

    assign empty = (count == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_dm_write_buffer.sv
module tb_dm_write_buffer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst, wr_valid, wr_ready, mem_wr_req, mem_wr_ack, rd_hazard, empty;
    logic [14:0]  wr_addr, rd_addr;
    logic [31:0]  wr_data;
    logic [12:0]  mem_wr_addr;
    logic [127:0] mem_wr_data;
    logic [3:0]   mem_wr_mask;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [12:0]  line;
        logic [127:0] data;
        logic [3:0]   mask;
    } ent_t;

    always #5 clk = ~clk;

    dm_write_buffer #(.DEPTH(DEPTH), .ADDR_W(15), .WORD_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_mask (mem_wr_mask),
        .mem_wr_ack  (mem_wr_ack),
        .rd_addr     (rd_addr),
        .rd_hazard   (rd_hazard),
        .empty       (empty)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        mem_wr_ack = 1'b0;
        rd_addr    = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_wr_req); end
        n_cmp++; if (mem_wr_addr !== 13'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_wr_addr); end
        n_cmp++; if (mem_wr_data !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", mem_wr_data); end
        n_cmp++; if (mem_wr_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %b want 0", mem_wr_mask); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", rd_hazard); end
    endtask

    task automatic test_single_write();
        bit saw;
        do_reset();
        mem_wr_ack = 1'b1;
        wr_valid   = 1'b1;
        wr_addr    = 15'h0012;
        wr_data    = 32'hDEADBEEF;
        #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b want 0", mem_wr_req); end
        n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_q: got %b want 0", empty); end
        tick();
        n_cmp++; if (mem_wr_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b want 1", mem_wr_req); end
        n_cmp++; if (mem_wr_addr !== 13'h004) begin n_fail++; $display("FAIL single_addr: got %h want 004", mem_wr_addr); end
        n_cmp++; if (mem_wr_mask !== 4'b0100) begin n_fail++; $display("FAIL single_mask: got %b want 0100", mem_wr_mask); end
        n_cmp++; if (mem_wr_data[95:64] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", mem_wr_data[95:64]); end
        tick();
        n_cmp++; if (mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL single_gap_req: got %b want 0", mem_wr_req); end
        n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_gap_empty: got %b want 0", empty); end
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", empty); end
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (mem_wr_req) saw = 1'b1;
            tick();
        end
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL single_extra_req: got %b want 0", saw); end
        mem_wr_ack = 1'b0;
    endtask

    task automatic test_fill();
        logic [14:0] addrs [5];
        logic [1:0]  sl;
        int          idx;
        addrs[0] = 15'h0100; addrs[1] = 15'h0205; addrs[2] = 15'h030A;
        addrs[3] = 15'h040F; addrs[4] = 15'h0510;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = addrs[i];
            wr_data  = 32'hA0000000 + i;
            #1;
            n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %b want 1", i, wr_ready); end
            tick();
        end
        wr_addr = addrs[4];
        wr_data = 32'hA0000004;
        #1;
        n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b want 0", wr_ready); end
        tick();
        n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_held: got %b want 0", wr_ready); end
        n_cmp++; if (mem_wr_req !== 1'b1) begin n_fail++; $display("FAIL fill_req: got %b want 1", mem_wr_req); end
        n_cmp++; if (mem_wr_addr !== addrs[0][14:2]) begin n_fail++; $display("FAIL fill_head: got %h want %h", mem_wr_addr, addrs[0][14:2]); end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_freed: got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        idx = 1;
        for (int c = 0; c < 60 && !(idx == 5 && empty); c++) begin
            mem_wr_ack = 1'b1;
            if (mem_wr_req && idx < 5) begin
                sl = addrs[idx][1:0];
                n_cmp++; if (mem_wr_addr !== addrs[idx][14:2]) begin n_fail++; $display("FAIL fill_order%0d: got %h want %h", idx, mem_wr_addr, addrs[idx][14:2]); end
                n_cmp++; if (mem_wr_mask !== (4'b0001 << sl)) begin n_fail++; $display("FAIL fill_mask%0d: got %b want %b", idx, mem_wr_mask, 4'b0001 << sl); end
                n_cmp++; if (mem_wr_data[sl*32 +: 32] !== 32'hA0000000 + idx) begin n_fail++; $display("FAIL fill_data%0d: got %h want %h", idx, mem_wr_data[sl*32 +: 32], 32'hA0000000 + idx); end
                idx++;
            end
            tick();
        end
        mem_wr_ack = 1'b0;
        n_cmp++; if (idx !== 5) begin n_fail++; $display("FAIL fill_drained: got %0d want 5", idx); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b want 1", empty); end
    endtask

    task automatic test_hazard();
        do_reset();
        wr_valid = 1'b1;
        wr_addr  = 15'h0101;
        wr_data  = 32'h12345678;
        tick();
        wr_valid = 1'b0;
        rd_addr  = 15'h0101; #1;
        n_cmp++; if (rd_hazard !== 1'b1) begin n_fail++; $display("FAIL haz_hit: got %b want 1", rd_hazard); end
        rd_addr  = 15'h0102; #1;
        n_cmp++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_word: got %b want 0", rd_hazard); end
        rd_addr  = 15'h0201; #1;
        n_cmp++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_line: got %b want 0", rd_hazard); end
        rd_addr  = 15'h0101;
        tick();
        n_cmp++; if (mem_wr_req !== 1'b1) begin n_fail++; $display("FAIL haz_req: got %b want 1", mem_wr_req); end
        n_cmp++; if (rd_hazard !== 1'b1) begin n_fail++; $display("FAIL haz_issue: got %b want 1", rd_hazard); end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        #1;
        n_cmp++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_popped: got %b want 0", rd_hazard); end
    endtask

    task automatic test_reset_mid_issue();
        bit saw;
        do_reset();
        wr_valid = 1'b1;
        wr_addr  = 15'h0333;
        wr_data  = 32'hCAFEF00D;
        tick();
        wr_valid = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 10 && !saw; c++) begin
            if (mem_wr_req) saw = 1'b1;
            else tick();
        end
        n_cmp++; if (saw !== 1'b1) begin n_fail++; $display("FAIL rmi_issue: got %b want 1", saw); end
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        rd_addr = 15'h0333;
        #1;
        n_cmp++; if (mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL rmi_req: got %b want 0", mem_wr_req); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rmi_empty: got %b want 1", empty); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rmi_ready: got %b want 1", wr_ready); end
        n_cmp++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL rmi_hazard: got %b want 0", rd_hazard); end
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_wr_req) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rmi_reappear: got %b want 0", saw); end
    endtask

    task automatic test_coalesce();
        logic [12:0]  rec_addr [4];
        logic [3:0]   rec_mask [4];
        logic [127:0] rec_data [4];
        int           nreq;
        do_reset();
        wr_valid = 1'b1; wr_addr = 15'h0200; wr_data = 32'h11111111;
        tick();
        wr_valid = 1'b0;
        tick();
        n_cmp++; if (mem_wr_req !== 1'b1) begin n_fail++; $display("FAIL coal_first_req: got %b want 1", mem_wr_req); end
        wr_valid = 1'b1; wr_addr = 15'h0040; wr_data = 32'hAAAA0000; #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL coal_ready_a: got %b want 1", wr_ready); end
        tick();
        wr_addr = 15'h0043; wr_data = 32'hBBBB0003; #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL coal_ready_b: got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        rd_addr  = 15'h0043; #1;
        n_cmp++; if (rd_hazard !== 1'b1) begin n_fail++; $display("FAIL coal_haz_b: got %b want 1", rd_hazard); end
        rd_addr  = 15'h0041; #1;
        n_cmp++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL coal_haz_w1: got %b want 0", rd_hazard); end
        nreq = 0;
        mem_wr_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (mem_wr_req) begin
                if (nreq < 4) begin
                    rec_addr[nreq] = mem_wr_addr;
                    rec_mask[nreq] = mem_wr_mask;
                    rec_data[nreq] = mem_wr_data;
                end
                nreq++;
            end
            tick();
        end
        mem_wr_ack = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL coal_empty: got %b want 1", empty); end
        n_cmp++; if (rec_addr[0] !== 13'h080) begin n_fail++; $display("FAIL coal_first_addr: got %h want 080", rec_addr[0]); end
        n_cmp++; if (rec_addr[1] !== 13'h010) begin n_fail++; $display("FAIL coal_a_addr: got %h want 010", rec_addr[1]); end
        n_cmp++; if (rec_data[1][31:0] !== 32'hAAAA0000) begin n_fail++; $display("FAIL coal_a_data: got %h want aaaa0000", rec_data[1][31:0]); end
`ifdef DM_WRITE_BUFFER_COALESCE_EN
        n_cmp++; if (nreq !== 2) begin n_fail++; $display("FAIL coal_nreq: got %0d want 2", nreq); end
        n_cmp++; if (rec_mask[1] !== 4'b1001) begin n_fail++; $display("FAIL coal_mask: got %b want 1001", rec_mask[1]); end
        n_cmp++; if (rec_data[1][127:96] !== 32'hBBBB0003) begin n_fail++; $display("FAIL coal_b_data: got %h want bbbb0003", rec_data[1][127:96]); end
`else
        n_cmp++; if (nreq !== 3) begin n_fail++; $display("FAIL coal_nreq: got %0d want 3", nreq); end
        n_cmp++; if (rec_mask[1] !== 4'b0001) begin n_fail++; $display("FAIL coal_mask_a: got %b want 0001", rec_mask[1]); end
        n_cmp++; if (rec_mask[2] !== 4'b1000) begin n_fail++; $display("FAIL coal_mask_b: got %b want 1000", rec_mask[2]); end
        n_cmp++; if (rec_data[2][127:96] !== 32'hBBBB0003) begin n_fail++; $display("FAIL coal_b_data: got %h want bbbb0003", rec_data[2][127:96]); end
`endif
    endtask

    // Reference model: a queue of pending line writes; a request on the memory side must
    // always present the oldest queued entry, which leaves the queue when it is acked.
    task automatic test_random();
        ent_t        mq [$];
        ent_t        e;
        logic [12:0] ln;
        logic [1:0]  sl;
        bit          exp_ready, exp_merge, exp_haz, dmatch, do_pop, do_push;
        do_reset();
        for (int cyc = 0; cyc < 700; cyc++) begin
            ln = 13'h010 + 13'($urandom_range(0, 3));
            sl = 2'($urandom_range(0, 3));
            wr_addr = {ln, sl};
            wr_data = $urandom;
            rd_addr = {13'h010 + 13'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if (cyc < 500) begin
                wr_valid   = ($urandom_range(0, 2) != 0);
                mem_wr_ack = ($urandom_range(0, 2) == 0);
            end else begin
                wr_valid   = 1'b0;
                mem_wr_ack = 1'b1;
            end
            #1;
`ifdef DM_WRITE_BUFFER_COALESCE_EN
            exp_merge = (mq.size() >= 2) && (mq[mq.size()-1].line == ln);
`else
            exp_merge = 1'b0;
`endif
            exp_ready = (mq.size() != DEPTH) || exp_merge;
            exp_haz = 1'b0;
            foreach (mq[i])
                if (mq[i].line == rd_addr[14:2] && mq[i].mask[rd_addr[1:0]]) exp_haz = 1'b1;
            n_cmp++; if (wr_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, wr_ready, exp_ready); end
            n_cmp++; if (rd_hazard !== exp_haz) begin n_fail++; $display("FAIL rnd_hazard c%0d: got %b want %b", cyc, rd_hazard, exp_haz); end
            if (mq.size() != 0) begin
                n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL rnd_empty c%0d: got %b want 0", cyc, empty); end
            end
            if (mem_wr_req) begin
                if (mq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rnd_spurious c%0d: got req=1 want 0 (nothing queued)", cyc);
                end else begin
                    dmatch = 1'b1;
                    for (int k = 0; k < 4; k++)
                        if (mq[0].mask[k] && mem_wr_data[k*32 +: 32] !== mq[0].data[k*32 +: 32])
                            dmatch = 1'b0;
                    n_cmp++; if (mem_wr_addr !== mq[0].line) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, mem_wr_addr, mq[0].line); end
                    n_cmp++; if (mem_wr_mask !== mq[0].mask) begin n_fail++; $display("FAIL rnd_mask c%0d: got %b want %b", cyc, mem_wr_mask, mq[0].mask); end
                    n_cmp++; if (dmatch !== 1'b1) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, mem_wr_data, mq[0].data); end
                end
            end
            do_pop  = mem_wr_req && mem_wr_ack && (mq.size() != 0);
            do_push = wr_valid && exp_ready;
            @(posedge clk);
            if (do_push && exp_merge) begin
                e = mq[mq.size()-1];
                e.data[sl*32 +: 32] = wr_data;
                e.mask[sl] = 1'b1;
                mq[mq.size()-1] = e;
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push && !exp_merge) begin
                e.line = ln;
                e.data = '0;
                e.data[sl*32 +: 32] = wr_data;
                e.mask = 4'b0001 << sl;
                mq.push_back(e);
            end
            #1;
        end
        n_cmp++; if (mq.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d pending want 0", mq.size()); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rnd_final_empty: got %b want 1", empty); end
        mem_wr_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_hazard();
        test_reset_mid_issue();
        test_coalesce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
